// File: rtl/multiplier_signed_pkg.sv
// Shared types and derived constants for the signed multi-limb multiplier.
// Operands are NUM_ELEMENTS signed limbs in redundant radix-2^WORD_LEN form;
// the product comes back as OUT_ELEMENTS normalized limbs in the same radix.
package multiplier_signed_pkg;

  localparam int NUM_ELEMENTS = 17;
  localparam int BIT_LEN      = 17;
  localparam int WORD_LEN     = 16;

  // Width of one column sum: a full signed limb product plus growth for
  // up to n products per column, plus one spare sign bit.
  function automatic int col_width(input int n, input int bit_len);
    return 2 * (bit_len + 1) + $clog2(n) + 1;
  endfunction

  localparam int COL_W        = col_width(NUM_ELEMENTS, BIT_LEN);
  localparam int OUT_ELEMENTS = 2 * NUM_ELEMENTS + 1;
  localparam int NUM_COLS     = 2 * NUM_ELEMENTS - 1;

  typedef logic signed [BIT_LEN:0]             limb_t;
  typedef logic signed [2*(BIT_LEN+1)-1:0]     prod_t;
  typedef logic signed [COL_W-1:0]             col_t;

endpackage

// File: rtl/multiplier_col_normalize.sv
// Combinational carry ripple that turns signed column sums into normalized
// limbs: every limb but the top one is a WORD_LEN-bit digit in
// [0, 2^WORD_LEN-1]; the top limb holds the signed remainder carry.
module multiplier_col_normalize
  import multiplier_signed_pkg::*;
(
  input  col_t  col [NUM_COLS],
  output limb_t c   [OUT_ELEMENTS]
);

  // One extra bit over a column so column plus incoming carry cannot wrap.
  localparam int T_W   = COL_W + 1;
  localparam int PAD_W = BIT_LEN + 1 - WORD_LEN;

  // Ripple from the least significant column, peeling one digit per limb.
  always_comb begin
    logic signed [T_W-1:0] carry;
    logic signed [T_W-1:0] t;
    carry = '0;
    t     = '0;
    for (int k = 0; k < OUT_ELEMENTS; k++) begin
      c[k] = '0;
    end
    for (int k = 0; k < NUM_COLS; k++) begin
      t     = T_W'(col[k]) + carry;
      c[k]  = {{PAD_W{1'b0}}, t[WORD_LEN-1:0]};
      carry = t >>> WORD_LEN;
    end
    // Columns beyond the last partial product are empty: only carry flows.
    for (int k = NUM_COLS; k < OUT_ELEMENTS - 1; k++) begin
      t     = carry;
      c[k]  = {{PAD_W{1'b0}}, t[WORD_LEN-1:0]};
      carry = t >>> WORD_LEN;
    end
    // The residual carry is small enough to fit a limb and keeps its sign.
    c[OUT_ELEMENTS-1] = carry[BIT_LEN:0];
  end

endmodule

// File: rtl/multiplier_signed.sv
// Two-stage pipelined signed multi-limb multiplier. Stage 1 forms every
// limb-by-limb partial product and sums them per column; stage 2 ripples
// carries through the registered columns to produce normalized limbs.
// One operand pair per cycle, no backpressure, synchronous active-high reset.
module multiplier_signed
  import multiplier_signed_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  limb_t a [NUM_ELEMENTS],
  input  limb_t b [NUM_ELEMENTS],
  output logic  out_valid,
  output limb_t c [OUT_ELEMENTS]
);

  prod_t pp      [NUM_ELEMENTS][NUM_ELEMENTS];
  col_t  col_sum [NUM_COLS];
  col_t  col_r   [NUM_COLS];
  logic  valid_r;
  limb_t c_norm  [OUT_ELEMENTS];

  // Partial-product array: both factors widened as signed before multiplying.
  for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_row
    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_pp
      assign pp[i][j] = prod_t'(a[i]) * prod_t'(b[j]);
    end
  end

  // Column adders: product a[i]*b[j] lands in column i+j.
  always_comb begin
    for (int k = 0; k < NUM_COLS; k++) begin
      col_sum[k] = '0;
    end
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
        col_sum[i+j] = col_sum[i+j] + col_t'(pp[i][j]);
      end
    end
  end

  // Stage 1 register: column sums and the first valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_COLS; k++) begin
        col_r[k] <= '0;
      end
      valid_r <= 1'b0;
    end else begin
      col_r   <= col_sum;
      valid_r <= in_valid;
    end
  end

  multiplier_col_normalize u_normalize (
    .col (col_r),
    .c   (c_norm)
  );

  // Stage 2 register: normalized product limbs and the output valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < OUT_ELEMENTS; k++) begin
        c[k] <= '0;
      end
      out_valid <= 1'b0;
    end else begin
      c         <= c_norm;
      out_valid <= valid_r;
    end
  end

endmodule

// File: tb/tb_multiplier_signed.sv
// Scoreboard bench for multiplier_signed: the driver computes the exact
// product A*B with wide integer arithmetic and queues it with the cycle it
// is due; a monitor on the falling edge rebuilds the value of c and checks it.
module tb_multiplier_signed;
  import multiplier_signed_pkg::*;

  typedef logic signed [639:0] big_t;
  typedef struct {
    big_t prod;
    int   due;
  } exp_t;

  logic  clk;
  logic  rst;
  logic  in_valid;
  limb_t a [NUM_ELEMENTS];
  limb_t b [NUM_ELEMENTS];
  logic  out_valid;
  limb_t c [OUT_ELEMENTS];

  limb_t va [NUM_ELEMENTS];
  limb_t vb [NUM_ELEMENTS];
  exp_t  q [$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  exp_t  m_e;
  big_t  m_s;
  big_t  m_top;
  limb_t m_top_l;
  logic  m_range;

  multiplier_signed dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .c         (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input big_t got, input big_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Exact integer value of the operands held in va/vb, multiplied.
  function automatic big_t ref_product();
    big_t sa, sb, t;
    sa = '0;
    sb = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      t  = va[i];
      sa = sa + (t <<< (WORD_LEN * i));
      t  = vb[i];
      sb = sb + (t <<< (WORD_LEN * i));
    end
    return sa * sb;
  endfunction

  function automatic big_t c_value();
    big_t s, t;
    s = '0;
    for (int k = 0; k < OUT_ELEMENTS; k++) begin
      t = c[k];
      s = s + (t <<< (WORD_LEN * k));
    end
    return s;
  endfunction

  function automatic logic c_is_zero();
    logic z;
    z = 1'b1;
    for (int k = 0; k < OUT_ELEMENTS; k++) begin
      if (c[k] !== '0) z = 1'b0;
    end
    return z;
  endfunction

  task automatic clear_ops();
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      va[i] = '0;
      vb[i] = '0;
    end
  endtask

  task automatic issue();
    exp_t e;
    @(posedge clk);
    #1;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    e.prod   = ref_product();
    e.due    = cyc + 2;
    q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every presented result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_output: got none expected result due at cycle %0d (now %0d)", q[0].due, cyc);
      q.delete(0);
    end
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: got out_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        m_e = q.pop_front();
        check("latency_cycle", big_t'(cyc), big_t'(m_e.due));
        m_s = c_value();
        check("product_value", m_s, m_e.prod);
        m_range = 1'b1;
        for (int k = 0; k < OUT_ELEMENTS - 1; k++) begin
          if (c[k] < 0 || c[k] > 18'sd65535) m_range = 1'b0;
        end
        check("low_limbs_in_range", big_t'(m_range), big_t'(1'b1));
        m_top   = m_e.prod >>> (WORD_LEN * (OUT_ELEMENTS - 1));
        m_top_l = m_top[BIT_LEN:0];
        check("top_limb", big_t'(c[OUT_ELEMENTS-1]), big_t'(m_top_l));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    rst      = 1'b1;
    in_valid = 1'b0;
    clear_ops();
    a = va;
    b = vb;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", big_t'(out_valid), big_t'(1'b0));
    check("reset_c_zero", big_t'(c_is_zero()), big_t'(1'b1));
    rst = 1'b0;

    // Directed corner cases, back to back.
    clear_ops();
    issue();
    clear_ops(); va[0] = 18'sd1;  vb[0] = 18'sd1;
    issue();
    clear_ops(); va[0] = -18'sd1; vb[0] = 18'sd1;
    issue();
    clear_ops(); va[16] = 18'sd65536; vb[16] = 18'sd65536;
    issue();
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      va[i] = 18'sd131071;
      vb[i] = -18'sd131071;
    end
    issue();
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      va[i] = -18'sd131072;
      vb[i] = -18'sd131072;
    end
    issue();
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      va[i] = -18'sd131072;
      vb[i] = 18'sd131071;
    end
    issue();
    repeat (3) idle();

    // Random full-range limbs, back to back, with a reset in the middle.
    for (int n = 0; n < 100; n++) begin
      if (n == 60) begin
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        // Results already on the output stay; anything still in flight is lost.
        while (q.size() > 0 && q[q.size()-1].due > cyc) q.delete(q.size() - 1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", big_t'(out_valid), big_t'(1'b0));
        check("midrst_c_zero", big_t'(c_is_zero()), big_t'(1'b1));
      end
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        r = $urandom();
        va[i] = r[17:0];
        r = $urandom();
        vb[i] = r[17:0];
      end
      issue();
    end

    idle();
    for (int w = 0; w < 10 && q.size() > 0; w++) idle();
    @(posedge clk);
    #1;
    check("scoreboard_drained", big_t'(q.size()), big_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
